// File: rtl/we_sched_pkg.sv
// Shared state encoding, event indices and default widths for the WETOP
// run scheduler.
package we_sched_pkg;

    localparam int DEF_CNT_W = 16;
    localparam int DEF_TMR_W = 32;

    // Bit positions inside the status-input edge detector vector.
    localparam int EV_SPI  = 0;
    localparam int EV_TASK = 1;
    localparam int EV_FULL = 2;
    localparam int EV_W    = 3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CFG       = 3'd1,
        S_WAIT_CFG  = 3'd2,
        S_TASK      = 3'd3,
        S_WAIT_TASK = 3'd4,
        S_FLIP      = 3'd5,
        S_GAP       = 3'd6,
        S_ERR       = 3'd7
    } sched_state_e;

endpackage

// File: rtl/we_edge_det.sv
// Registered-history rising-edge detector; rise is combinational on the
// current level against the value seen on the previous clock.
module we_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] level,
    output logic [W-1:0] rise
);

    logic [W-1:0] level_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            level_prev <= '0;
        end else begin
            level_prev <= level;
        end
    end

    assign rise = level & ~level_prev;

endmodule

// File: rtl/we_task_sched.sv
// Hardware run scheduler for WETOP: N runs of (config, task, flip) with an
// inter-run gap, a per-wait watchdog and FIFO-full event counting.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | waiting for start; settings latched on accepted start
// CFG         | trigger_config pulse
// WAIT_CFG    | waiting for done_spi rise, watchdog running
// TASK        | trigger_task pulse
// WAIT_TASK   | waiting for done_task rise, watchdog running
// FLIP        | force_flip pulse after a run
// GAP         | inter-run gap countdown
// ERR         | watchdog expired; err_timeout set, back to IDLE
module we_task_sched
    import we_sched_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int TMR_W = DEF_TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_runs,
    input  logic [TMR_W-1:0] gap_cycles,
    input  logic [TMR_W-1:0] timeout_cycles,
    input  logic             cfg_every_run,
    input  logic             flip_every_run,
    input  logic             done_spi,
    input  logic             done_task,
    input  logic             full_ppfifo,
    output logic             trigger_config,
    output logic             trigger_task,
    output logic             force_flip,
    output logic             busy,
    output logic             seq_done,
    output logic             err_timeout,
    output logic             aborted,
    output logic [CNT_W-1:0] run_idx,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sched_state_e     state;
    sched_state_e     state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic [CNT_W-1:0] run_idx_nxt;
    logic             seq_done_nxt;
    logic             err_nxt;
    logic             aborted_nxt;

    logic [CNT_W-1:0] n_runs_q;
    logic [TMR_W-1:0] gap_q;
    logic [TMR_W-1:0] tmo_q;
    logic             cfg_every_q;
    logic             flip_every_q;

    logic [EV_W-1:0]  ev;
    logic             start_ok;
    logic             tmo_expired;

    we_edge_det #(
        .W (EV_W)
    ) u_edge_det (
        .clk   (clk),
        .rst   (rst),
        .level ({full_ppfifo, done_task, done_spi}),
        .rise  (ev)
    );

    assign start_ok    = (state == S_IDLE) && start;
    // The shared timer holds timeout-1 in the WAIT states, so zero means the
    // last permitted cycle has been reached.
    assign tmo_expired = (tmo_q != '0) && (tmr == '0);

    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        run_idx_nxt  = run_idx;
        seq_done_nxt = 1'b0;
        err_nxt      = err_timeout;
        aborted_nxt  = aborted;

        if (abort && (state != S_IDLE)) begin
            state_nxt   = S_IDLE;
            aborted_nxt = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        run_idx_nxt = '0;
                        err_nxt     = 1'b0;
                        aborted_nxt = 1'b0;
                        if (n_runs == '0) begin
                            seq_done_nxt = 1'b1;
                        end else begin
                            state_nxt = S_CFG;
                        end
                    end
                end
                S_CFG: begin
                    state_nxt = S_WAIT_CFG;
                    tmr_nxt   = tmo_q - TMR_ONE;
                end
                S_WAIT_CFG: begin
                    if (ev[EV_SPI]) begin
                        state_nxt = S_TASK;
                    end else if (tmo_expired) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
                S_TASK: begin
                    state_nxt = S_WAIT_TASK;
                    tmr_nxt   = tmo_q - TMR_ONE;
                end
                S_WAIT_TASK: begin
                    if (ev[EV_TASK]) begin
                        run_idx_nxt = run_idx + CNT_ONE;
                        if (flip_every_q) begin
                            state_nxt = S_FLIP;
                        end else if (run_idx_nxt < n_runs_q) begin
                            state_nxt = S_GAP;
                            tmr_nxt   = gap_q;
                        end else begin
                            state_nxt    = S_IDLE;
                            seq_done_nxt = 1'b1;
                        end
                    end else if (tmo_expired) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
                S_FLIP: begin
                    if (run_idx < n_runs_q) begin
                        state_nxt = S_GAP;
                        tmr_nxt   = gap_q;
                    end else begin
                        state_nxt    = S_IDLE;
                        seq_done_nxt = 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr == '0) begin
                        state_nxt = cfg_every_q ? S_CFG : S_TASK;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
                S_ERR: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            tmr            <= '0;
            n_runs_q       <= '0;
            gap_q          <= '0;
            tmo_q          <= '0;
            cfg_every_q    <= 1'b0;
            flip_every_q   <= 1'b0;
            trigger_config <= 1'b0;
            trigger_task   <= 1'b0;
            force_flip     <= 1'b0;
            busy           <= 1'b0;
            seq_done       <= 1'b0;
            err_timeout    <= 1'b0;
            aborted        <= 1'b0;
            run_idx        <= '0;
            ovf_cnt        <= '0;
        end else begin
            state          <= state_nxt;
            tmr            <= tmr_nxt;
            trigger_config <= (state_nxt == S_CFG);
            trigger_task   <= (state_nxt == S_TASK);
            force_flip     <= (state_nxt == S_FLIP);
            busy           <= (state_nxt != S_IDLE);
            seq_done       <= seq_done_nxt;
            err_timeout    <= err_nxt;
            aborted        <= aborted_nxt;
            run_idx        <= run_idx_nxt;

            if (start_ok) begin
                n_runs_q     <= n_runs;
                gap_q        <= gap_cycles;
                tmo_q        <= timeout_cycles;
                cfg_every_q  <= cfg_every_run;
                flip_every_q <= flip_every_run;
            end

            if (start_ok) begin
                ovf_cnt <= '0;
            end else if (busy && ev[EV_FULL] && (ovf_cnt != CNT_MAX)) begin
                ovf_cnt <= ovf_cnt + CNT_ONE;
            end
        end
    end

endmodule
